// File: rtl/raw2gray_bayer_pkg.sv
// Shared camera-pipeline constants: default sample width, frame geometry and
// the coordinate widths of the half-resolution gray stream.
package raw2gray_bayer_pkg;

    localparam int DATA_WIDTH_DEF = 12;
    localparam int FRAME_WIDTH    = 640;
    localparam int FRAME_HEIGHT   = 480;
    localparam int GRAY_X_W       = $clog2(FRAME_WIDTH / 2);
    localparam int GRAY_Y_W       = $clog2(FRAME_HEIGHT / 2);

endpackage

// File: rtl/raw2gray_bayer_if.sv
// RAW-in / gray-out stream bundle. The master side feeds RAW samples and
// receives gray pixels; the slave side is the converter itself.
interface raw2gray_bayer_if
    import raw2gray_bayer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int X_WIDTH    = GRAY_X_W,
    parameter int Y_WIDTH    = GRAY_Y_W
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_sof;
    logic [DATA_WIDTH-1:0] out_gray;
    logic                  out_valid;
    logic [X_WIDTH-1:0]    out_x;
    logic [Y_WIDTH-1:0]    out_y;
    logic                  out_eof;

    modport master (
        output in_data, in_valid, in_sof,
        input  out_gray, out_valid, out_x, out_y, out_eof
    );

    modport slave (
        input  in_data, in_valid, in_sof,
        output out_gray, out_valid, out_x, out_y, out_eof
    );
endinterface

// File: rtl/raw2gray_bayer_shift_reg.sv
// Enable-gated shift register used as a one-line delay: the output is the
// sample that entered SHIFT_LENGTH enabled cycles earlier.
module raw2gray_bayer_shift_reg #(
    parameter int DATA_WIDTH   = 12,
    parameter int SHIFT_LENGTH = 640
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data
);
    logic [DATA_WIDTH-1:0] r_mem [SHIFT_LENGTH];

    // Delay line storage, cleared on reset, shifts only when enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < SHIFT_LENGTH; k++) begin
                r_mem[k] <= '0;
            end
        end else if (i_en) begin
            r_mem[0] <= i_data;
            for (int k = 1; k < SHIFT_LENGTH; k++) begin
                r_mem[k] <= r_mem[k-1];
            end
        end
    end

    assign o_data = r_mem[SHIFT_LENGTH-1];
endmodule

// File: rtl/raw2gray_bayer.sv
// Bayer RAW to half-resolution gray: each 2x2 quad is averaged into one pixel,
// emitted one clock after the quad's bottom-right sample arrives.
module raw2gray_bayer
    import raw2gray_bayer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int WIDTH      = FRAME_WIDTH,
    parameter int HEIGHT     = FRAME_HEIGHT
) (
    input  logic             clk,
    input  logic             rst,
    raw2gray_bayer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int XW = $clog2(WIDTH / 2);
    localparam int YW = $clog2(HEIGHT / 2);
    localparam int SW = DATA_WIDTH + 2;

    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic [DATA_WIDTH-1:0] r_prev_cur;
    logic [DATA_WIDTH-1:0] r_prev_above;
    logic [DATA_WIDTH-1:0] r_out_gray;
    logic                  r_out_valid;
    logic [XW-1:0]         r_out_x;
    logic [YW-1:0]         r_out_y;
    logic                  r_out_eof;

    logic [DATA_WIDTH-1:0] w_above;
    logic [CW-1:0]         w_col;
    logic [RW-1:0]         w_row;
    logic [CW-1:0]         w_col_nxt;
    logic [RW-1:0]         w_row_nxt;
    logic [SW-1:0]         w_sum;
    logic                  w_emit;
    logic                  w_last;

    raw2gray_bayer_shift_reg #(
        .DATA_WIDTH   (DATA_WIDTH),
        .SHIFT_LENGTH (WIDTH)
    ) u_line_buf (
        .clk    (clk),
        .rst    (rst),
        .i_en   (bus.in_valid),
        .i_data (bus.in_data),
        .o_data (w_above)
    );

    // Effective position (start-of-frame forces 0,0), next position and quad sum.
    always_comb begin
        w_col     = bus.in_sof ? '0 : r_col;
        w_row     = bus.in_sof ? '0 : r_row;
        w_col_nxt = '0;
        w_row_nxt = w_row;
        if (w_col == CW'(WIDTH - 1)) begin
            w_col_nxt = '0;
            if (w_row == RW'(HEIGHT - 1)) begin
                w_row_nxt = '0;
            end else begin
                w_row_nxt = w_row + RW'(1);
            end
        end else begin
            w_col_nxt = w_col + CW'(1);
            w_row_nxt = w_row;
        end
        w_emit = bus.in_valid & w_col[0] & w_row[0];
        w_last = (w_col == CW'(WIDTH - 1)) && (w_row == RW'(HEIGHT - 1));
        w_sum  = {2'b00, bus.in_data} + {2'b00, r_prev_cur}
               + {2'b00, w_above}     + {2'b00, r_prev_above};
    end

    // Raster counters and the one-sample horizontal delay of both lines.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_prev_cur   <= '0;
            r_prev_above <= '0;
        end else if (bus.in_valid) begin
            r_col        <= w_col_nxt;
            r_row        <= w_row_nxt;
            r_prev_cur   <= bus.in_data;
            r_prev_above <= w_above;
        end
    end

    // Output register: the >>2 drops the two fraction bits of the 4-sample sum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_gray  <= '0;
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_eof   <= 1'b0;
        end else if (w_emit) begin
            r_out_gray  <= DATA_WIDTH'(w_sum >> 2);
            r_out_valid <= 1'b1;
            r_out_x     <= w_col[CW-1:1];
            r_out_y     <= w_row[RW-1:1];
            r_out_eof   <= w_last;
        end else begin
            r_out_valid <= 1'b0;
            r_out_eof   <= 1'b0;
        end
    end

    assign bus.out_gray  = r_out_gray;
    assign bus.out_valid = r_out_valid;
    assign bus.out_x     = r_out_x;
    assign bus.out_y     = r_out_y;
    assign bus.out_eof   = r_out_eof;
endmodule

// File: tb/tb_raw2gray_bayer.sv
// Directed bench for raw2gray_bayer on a 4x4 RAW frame (2x2 gray output).
module tb_raw2gray_bayer;
    localparam int DW = 12;
    localparam int W  = 4;
    localparam int H  = 4;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [DW-1:0] frm [16];
    logic [DW-1:0] eg  [4];

    raw2gray_bayer_if #(.DATA_WIDTH(DW), .X_WIDTH(1), .Y_WIDTH(1)) bus ();

    raw2gray_bayer #(.DATA_WIDTH(DW), .WIDTH(W), .HEIGHT(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Samples 5,7,13,15 of a 4x4 frame close quads 0..3.
    function automatic int quad_of(input int i);
        case (i)
            5:       return 0;
            7:       return 1;
            13:      return 2;
            15:      return 3;
            default: return -1;
        endcase
    endfunction

    task automatic drive(input logic [DW-1:0] d, input logic sof, input int q,
                         input logic [DW-1:0] g, input string tag);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sof   = sof;
        @(posedge clk);
        #1;
        chk($sformatf("%s valid", tag), 32'(bus.out_valid), (q >= 0) ? 32'd1 : 32'd0);
        if (q >= 0) begin
            chk($sformatf("%s gray q%0d", tag, q), 32'(bus.out_gray), 32'(g));
            chk($sformatf("%s x q%0d", tag, q), 32'(bus.out_x), 32'(q % 2));
            chk($sformatf("%s y q%0d", tag, q), 32'(bus.out_y), 32'(q / 2));
            chk($sformatf("%s eof q%0d", tag, q), 32'(bus.out_eof), (q == 3) ? 32'd1 : 32'd0);
        end else begin
            chk($sformatf("%s eof", tag), 32'(bus.out_eof), 32'd0);
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_data  = DW'($urandom);
            bus.in_sof   = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("%s gap valid", tag), 32'(bus.out_valid), 32'd0);
        end
    endtask

    task automatic run_frame(input logic sof_first, input logic gaps, input string tag);
        for (int i = 0; i < 16; i++) begin
            int q;
            q = quad_of(i);
            drive(frm[i], (i == 0) ? sof_first : 1'b0, q, (q >= 0) ? eg[q] : DW'(0), tag);
            if (gaps) begin
                idle((i == 6) ? 5 : 1, tag);
            end
        end
    endtask

    task automatic fill_const(input logic [DW-1:0] v);
        for (int i = 0; i < 16; i++) frm[i] = v;
        for (int q = 0; q < 4; q++) eg[q] = v;
    endtask

    task automatic fill_bayer(input logic [DW-1:0] r, input logic [DW-1:0] g1,
                              input logic [DW-1:0] g2, input logic [DW-1:0] b,
                              input logic [DW-1:0] e);
        for (int i = 0; i < 16; i++) begin
            if ((i / 4) % 2 == 0) frm[i] = ((i % 2) == 0) ? r : g1;
            else                  frm[i] = ((i % 2) == 0) ? g2 : b;
        end
        for (int q = 0; q < 4; q++) eg[q] = e;
    endtask

    // Distinct values per quad: 140/4=35, 220/4=55, 14/4=3, 23/4=5.
    task automatic fill_distinct();
        frm = '{12'd10, 12'd20, 12'd30, 12'd40,
                12'd50, 12'd60, 12'd70, 12'd80,
                12'd1,  12'd2,  12'd3,  12'd4,
                12'd5,  12'd6,  12'd7,  12'd9};
        eg  = '{12'd35, 12'd55, 12'd3, 12'd5};
    endtask

    initial begin
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_sof   = 1'b0;
        #23;
        chk("reset gray",  32'(bus.out_gray),  32'd0);
        chk("reset valid", 32'(bus.out_valid), 32'd0);
        chk("reset x",     32'(bus.out_x),     32'd0);
        chk("reset y",     32'(bus.out_y),     32'd0);
        chk("reset eof",   32'(bus.out_eof),   32'd0);
        @(negedge clk);
        rst = 1'b1;

        fill_const(12'd100);
        run_frame(1'b1, 1'b0, "const");

        fill_distinct();
        run_frame(1'b0, 1'b0, "wrap");

        fill_bayer(12'd400, 12'd200, 12'd200, 12'd0, 12'd200);
        run_frame(1'b1, 1'b0, "bayer");

        fill_bayer(12'd3, 12'd0, 12'd0, 12'd0, 12'd0);
        run_frame(1'b1, 1'b0, "trunc");

        fill_const(12'd4095);
        run_frame(1'b1, 1'b0, "sat");

        fill_distinct();
        run_frame(1'b1, 1'b1, "gaps");

        // Abort after five samples; a missed restart would emit on the sixth.
        for (int i = 0; i < 5; i++) drive(12'd4095, 1'b0, -1, 12'd0, "abort");
        fill_distinct();
        run_frame(1'b1, 1'b0, "sof_mid");

        // Reset after nine samples; out_gray/out_x are nonzero just before it.
        for (int i = 0; i < 9; i++) begin
            int q;
            q = quad_of(i);
            drive(frm[i], (i == 0) ? 1'b1 : 1'b0, q, (q >= 0) ? eg[q] : DW'(0), "pre_rst");
        end
        #2;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("mid rst gray",  32'(bus.out_gray),  32'd0);
        chk("mid rst valid", 32'(bus.out_valid), 32'd0);
        chk("mid rst x",     32'(bus.out_x),     32'd0);
        chk("mid rst y",     32'(bus.out_y),     32'd0);
        chk("mid rst eof",   32'(bus.out_eof),   32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_frame(1'b0, 1'b0, "post_rst");

        idle(2, "tail");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
